// File: rtl/ad_bus_pkg.sv
// Shared types for the multiplexed address/data bus master: one-hot phase
// states, default bus width and the registered request command.
package ad_bus_pkg;

  localparam int unsigned AD_W_DEFAULT = 8;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    ADDR   = 5'b00010,
    STROBE = 5'b00100,
    TURN   = 5'b01000,
    DONE   = 5'b10000
  } ad_bus_state_e;

  typedef struct packed {
    logic                    write;
    logic [AD_W_DEFAULT-1:0] addr;
    logic [AD_W_DEFAULT-1:0] wdata;
  } ad_bus_cmd_t;

endpackage

// File: rtl/ad_bus_phase_counter.sv
// Loadable down-counter with a zero flag; times the STROBE and TURN phases.
module ad_bus_phase_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ad_bus_master.sv
// Initiator for the multiplexed AD bus: one ADDR / STROBE / TURN / DONE
// bus cycle per accepted request, with a one-cycle response pulse.
module ad_bus_master
  import ad_bus_pkg::*;
#(
  parameter int unsigned AD_W          = AD_W_DEFAULT,
  parameter int          STROBE_CYCLES = 2,
  parameter int          TURN_CYCLES   = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AD_W-1:0] req_addr,
  input  logic [AD_W-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [AD_W-1:0] rsp_rdata,
  output logic [AD_W-1:0] ad_out,
  output logic            ad_oe,
  input  logic [AD_W-1:0] ad_in,
  output logic            ALE,
  output logic            CS,
  output logic            rdb,
  output logic            wrb
);

  if (STROBE_CYCLES < 1 || TURN_CYCLES < 1) begin : g_bad_cycles
    $error("ad_bus_master: STROBE_CYCLES and TURN_CYCLES must both be >= 1");
  end

  localparam int unsigned MAX_CYC     = (STROBE_CYCLES > TURN_CYCLES) ? STROBE_CYCLES : TURN_CYCLES;
  localparam int unsigned CNT_W       = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);

  // Same shape as ad_bus_cmd_t, but sized by AD_W so non-default widths build.
  typedef struct packed {
    logic            write;
    logic [AD_W-1:0] addr;
    logic [AD_W-1:0] wdata;
  } cmd_t;

  ad_bus_state_e   state_q, state_d;
  cmd_t            cmd_q, cmd_d;
  logic [AD_W-1:0] rdata_q, rdata_d;
  logic            cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  ad_bus_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    rdata_d      = rdata_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cmd_d   = '{write: req_write, addr: req_addr, wdata: req_wdata};
          state_d = ADDR;
        end
      end
      ADDR: begin
        cnt_load     = 1'b1;
        cnt_load_val = STROBE_LOAD;
        state_d      = STROBE;
      end
      STROBE: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = TURN_LOAD;
          state_d      = TURN;
          if (!cmd_q.write) begin
            rdata_d = ad_in;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      TURN: begin
        if (cnt_zero) begin
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are pure decodes of the state plus the registered command.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ALE       = 1'b0;
    CS        = 1'b0;
    rdb       = 1'b1;
    wrb       = 1'b1;
    ad_oe     = 1'b0;
    ad_out    = '0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      ADDR: begin
        ALE    = 1'b1;
        CS     = 1'b1;
        ad_oe  = 1'b1;
        ad_out = cmd_q.addr;
      end
      STROBE: begin
        CS = 1'b1;
        if (cmd_q.write) begin
          wrb    = 1'b0;
          ad_oe  = 1'b1;
          ad_out = cmd_q.wdata;
        end else begin
          rdb = 1'b0;
        end
      end
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
    end
  end

  assign rsp_rdata = rdata_q;

endmodule
